// File: rtl/bit_serial_adder_pkg.sv
// Package: bit_serial_adder_pkg
// Shared definitions for the bit-serial adder.
//  - state_e   : FSM state encoding (idle / run / done)
//  - cnt_width : width of the bit counter for a given operand width
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must hold 0..width-1. Widths below 2 still get one bit so the
    // counter never collapses to a zero-width vector.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// Module: fa_cell
// Purely combinational 1-bit full adder; the only arithmetic in the block.
// Ports:
//  a, b  in   1  addend bits
//  ci    in   1  carry in
//  s     out  1  sum bit
//  c     out  1  carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ ci;
    assign c = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Module: bit_serial_adder
// WIDTH-bit adder that streams its operands LSB-first through one full-adder
// cell, one bit per clock, then presents the parallel sum and carry-out with
// a valid/ready handshake on both sides.
// Ports:
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      a, b, ci valid
//  in_ready   out  1      block idle and able to take operands
//  a, b       in   WIDTH  operands
//  ci         in   1      carry-in
//  out_valid  out  1      sum/co valid
//  out_ready  in   1      consumer takes sum/co
//  sum        out  WIDTH  registered sum, a+b+ci mod 2^WIDTH
//  co         out  1      registered carry-out
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e          state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_sr_q;
    logic             cy_q;
    logic [CntW-1:0]  cnt_q;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH-1:0] sum_sr_next;

    fa_cell u_fa_cell (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (cy_q),
        .s  (cell_s),
        .c  (cell_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB of the
    // result has walked down to bit 0.
    assign sum_sr_next = {cell_s, sum_sr_q[WIDTH-1:1]};

    // Gated by rst so the source never sees a handshake during reset.
    assign in_ready = (state_q == StIdle) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            cy_q      <= 1'b0;
            cnt_q     <= '0;
            sum       <= '0;
            co        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        cy_q    <= ci;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_sr_q <= sum_sr_next;
                    cy_q     <= cell_c;
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    if (cnt_q == CntLast) begin
                        // Capture the finished result straight into the output
                        // registers so sum/co only change on completion.
                        sum       <= sum_sr_next;
                        co        <= cell_c;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: an 8-bit instance for directed,
// backpressure, reset and streaming sequences, and a 4-bit instance for a
// random sweep against a plain-arithmetic model.
module tb_bit_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic       iv8, ir8, ov8, or8, ci8, co8;
    logic [7:0] a8, b8, sum8;
    logic       iv4, ir4, ov4, or4, ci4, co4;
    logic [3:0] a4, b4, sum4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .ci        (ci8),
        .out_valid (ov8),
        .out_ready (or8),
        .sum       (sum8),
        .co        (co8)
    );

    bit_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .ci        (ci4),
        .out_valid (ov4),
        .out_ready (or4),
        .sum       (sum4),
        .co        (co4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       co;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact (WIDTH+1)-bit sum from plain integer arithmetic.
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y,
                                            input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[8:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation with bp cycles of held-off out_ready in DONE.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic [7:0] es, input logic ec, input int bp, input string nm);
        int n;
        n = 0;
        while (!ir8 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_in_ready"}, 32'(ir8), 32'd1);
        a8  = x;
        b8  = y;
        ci8 = c;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        chk({nm, "_busy"}, 32'(ir8), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ov8 && n < 40);
        chk({nm, "_latency"}, 32'(n), 32'd8);
        chk({nm, "_sum"}, 32'(sum8), 32'(es));
        chk({nm, "_co"}, 32'(co8), 32'(ec));
        for (int i = 0; i < bp; i++) begin
            tick();
            chk({nm, "_hold"}, {22'd0, ir8, ov8, co8, sum8}, {22'd0, 1'b0, 1'b1, ec, es});
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk({nm, "_released"}, {30'd0, ov8, ir8}, {30'd0, 1'b0, 1'b1});
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c,
                       input logic [4:0] exp, input string nm);
        int n;
        n = 0;
        while (!ir4 && n < 20) begin
            tick();
            n++;
        end
        a4  = x;
        b4  = y;
        ci4 = c;
        iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ov4 && n < 20);
        chk({nm, "_lat"}, 32'(n), 32'd4);
        chk(nm, {27'd0, co4, sum4}, {27'd0, exp});
    endtask

    initial begin
        int          cyc;
        int          last_acc;
        int          done_cnt;
        int          seen_ov;
        logic [8:0]  exp_q[$];
        logic [8:0]  e9;
        int unsigned ra, rb, rc;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; ci4 = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready8", 32'(ir8), 32'd0);
        chk("rst_in_ready4", 32'(ir4), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_state8", {21'd0, ir8, ov8, co8, sum8}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        chk("reset_state4", {25'd0, ir4, ov4, co4, sum4}, {25'd0, 1'b1, 1'b0, 1'b0, 4'h0});

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].co, 0,
                $sformatf("vec%0d", i));
        end

        // Backpressure: result and flags must hold for five cycles.
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5, "backpressure");

        // Reset after three RUN cycles discards the operation.
        a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("midrun_rst_in_ready", 32'(ir8), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(ir8), 32'd1);
        seen_ov = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov8) seen_ov++;
            tick();
        end
        chk("discarded_no_out_valid", 32'(seen_ov), 32'd0);
        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, "after_rst");

        // Streaming with in_valid/out_ready high; operands and in_valid churn
        // while busy and must not disturb the running operation.
        or8 = 1'b1;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        ci8 = 1'($urandom);
        cyc = 0;
        last_acc = -1;
        done_cnt = 0;
        while (done_cnt < 6 && cyc < 200) begin
            if (ov8) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e9 = exp_q.pop_front();
                    chk("stream_result", {23'd0, co8, sum8}, {23'd0, e9});
                end
                done_cnt++;
            end
            if (ir8) begin
                iv8 = 1'b1;
                if (last_acc >= 0) chk("stream_interval", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                exp_q.push_back(ref_add8(a8, b8, ci8));
            end else begin
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                ci8 = 1'($urandom);
                iv8 = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        iv8 = 1'b0;
        chk("stream_completed", 32'(done_cnt), 32'd6);
        repeat (12) tick();
        or8 = 1'b0;

        // Width-4 random sweep plus the all-ones corner.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            rc = $urandom_range(0, 1);
            op4(4'(ra), 4'(rb), 1'(rc), 5'(ra + rb + rc), "rand4");
        end
        op4(4'hF, 4'hF, 1'b1, 5'h1F, "max4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
